// File: rtl/gerador_pulso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gerador_pulso_pkg
// Description : Shared state encoding and parameter defaults for the
//               debounced push-button pulse generator.
// Revision    : 1.0 - initial release
// ============================================================================
package gerador_pulso_pkg;

  // Debounce FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    FILTRA_PRESS = 2'd1,
    PRESSIONADO  = 2'd2,
    FILTRA_SOLTA = 2'd3
  } estado_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned REPEAT_DELAY_DEF    = 8;
  localparam int unsigned REPEAT_PERIOD_DEF   = 3;

  // Wide enough for any 16-bit repeat delay or period
  localparam int unsigned REPEAT_CNT_W = 16;

  // The debounced level is high while the button is considered held,
  // including the release-filtering window.
  function automatic logic nivel_estavel(input estado_t s);
    return (s == PRESSIONADO) || (s == FILTRA_SOLTA);
  endfunction

endpackage : gerador_pulso_pkg
`default_nettype wire

// File: rtl/sincronizador_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sincronizador_2ff
// Description : Two-flop synchronizer for the raw push-button level.
//               Asynchronous active-low clear forces both stages to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sincronizador_2ff (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Shift the raw level through the two synchronizing stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages with asynchronous clear
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : sincronizador_2ff
`default_nettype wire

// File: rtl/gerador_pulso_debounce.sv
`default_nettype none
// ============================================================================
// Module      : gerador_pulso_debounce
// Description : Debounces a bouncing push-button and emits one registered
//               single-cycle strobe per accepted press (gated by habilita).
//               Optional auto-repeat while held: define
//               GERADOR_PULSO_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gerador_pulso_debounce
  import gerador_pulso_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic clear,
  input  logic botao,
  input  logic habilita,
  output logic pulso,
  output logic estavel
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Parameter legality, evaluated at elaboration
  if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 65535)) begin : g_chk_debounce
    $error("DEBOUNCE_CYCLES must be in 2..65535");
  end
  if ((REPEAT_PERIOD < 2) || (REPEAT_DELAY < 1)) begin : g_chk_repeat
    $error("REPEAT_PERIOD must be >= 2 and REPEAT_DELAY >= 1");
  end

  logic             bot_s;
  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe;
  logic             rep_strobe;
  logic             pulso_q, pulso_d;
  logic             estavel_q, estavel_d;

  sincronizador_2ff u_sync (
    .clk   (clk),
    .clear (clear),
    .d     (botao),
    .q     (bot_s)
  );

`ifdef GERADOR_PULSO_AUTO_REPEAT_EN
  logic [REPEAT_CNT_W-1:0] rep_q, rep_d;
  logic                    rep_fase_q, rep_fase_d;
  logic                    entra_press;
  logic [REPEAT_CNT_W-1:0] rep_alvo;

  // Count hold time in PRESSIONADO: first target is the initial delay,
  // afterwards the repeat period; everything clears whenever we leave.
  always_comb begin
    rep_d       = '0;
    rep_fase_d  = 1'b0;
    rep_strobe  = 1'b0;
    rep_alvo    = rep_fase_q ? REPEAT_CNT_W'(REPEAT_PERIOD) : REPEAT_CNT_W'(REPEAT_DELAY);
    entra_press = bot_s && (((estado_q == FILTRA_PRESS) && (cnt_q == CNT_LAST)) ||
                            (estado_q == FILTRA_SOLTA));
    if ((estado_q == PRESSIONADO) && bot_s) begin
      if (rep_q == rep_alvo) begin
        rep_strobe = 1'b1;
        rep_d      = REPEAT_CNT_W'(1);
        rep_fase_d = 1'b1;
      end else begin
        rep_d      = rep_q + REPEAT_CNT_W'(1);
        rep_fase_d = rep_fase_q;
      end
    end else if (entra_press) begin
      rep_d = REPEAT_CNT_W'(1);
    end
  end

  // Repeat counter registers
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      rep_q      <= '0;
      rep_fase_q <= 1'b0;
    end else begin
      rep_q      <= rep_d;
      rep_fase_q <= rep_fase_d;
    end
  end
`else
  assign rep_strobe = 1'b0;
`endif

  // Debounce FSM next state, filter counter and internal strobe
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    strobe   = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (bot_s) begin
          estado_d = FILTRA_PRESS;
          cnt_d    = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      FILTRA_PRESS: begin
        if (!bot_s) begin
          estado_d = OCIOSO;
          cnt_d    = '0;
        end else if (cnt_q == CNT_LAST) begin
          estado_d = PRESSIONADO;
          cnt_d    = '0;
          strobe   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSIONADO: begin
        if (!bot_s) begin
          estado_d = FILTRA_SOLTA;
          cnt_d    = CNT_W'(1);
        end else begin
          cnt_d  = '0;
          strobe = rep_strobe;
        end
      end
      FILTRA_SOLTA: begin
        if (bot_s) begin
          estado_d = PRESSIONADO;
          cnt_d    = '0;
        end else if (cnt_q == CNT_LAST) begin
          estado_d = OCIOSO;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        estado_d = OCIOSO;
        cnt_d    = '0;
      end
    endcase
    pulso_d   = strobe & habilita;
    estavel_d = nivel_estavel(estado_d);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      estado_q  <= OCIOSO;
      cnt_q     <= '0;
      pulso_q   <= 1'b0;
      estavel_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      pulso_q   <= pulso_d;
      estavel_q <= estavel_d;
    end
  end

  assign pulso   = pulso_q;
  assign estavel = estavel_q;

endmodule : gerador_pulso_debounce
`default_nettype wire

// File: tb/tb_gerador_pulso_debounce.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_gerador_pulso_debounce
// Description : Self-checking bench; expected pulse edges are queued when a
//               press is driven and popped when pulso is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gerador_pulso_debounce;

  logic clk      = 1'b0;
  logic clear    = 1'b1;
  logic botao    = 1'b0;
  logic habilita = 1'b1;
  logic pulso;
  logic estavel;

  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;
  int   exp_q[$];
  int   exp_e;
  logic [3:0] cont4 = 4'd0;
  logic pulso_ant = 1'b0;

  gerador_pulso_debounce dut (
    .clk      (clk),
    .clear    (clear),
    .botao    (botao),
    .habilita (habilita),
    .pulso    (pulso),
    .estavel  (estavel)
  );

  always #5 clk = ~clk;

  // Edge numbering plus the downstream 4-bit counter fed by pulso
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (pulso === 1'b1) cont4 <= cont4 + 4'd1;
  end

  // Scoreboard monitor: every observed pulse must match the queue head
  always @(negedge clk) begin
    if (pulso === 1'b1) begin
      checks++;
      if (pulso_ant) begin
        failures++;
        $display("FAIL pulso_consecutivo edge=%0d got=1 expected=0", edge_n);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pulso_inesperado edge=%0d got=pulse expected=none", edge_n);
      end else begin
        exp_e = exp_q.pop_front();
        if (exp_e != edge_n) begin
          failures++;
          $display("FAIL pulso_edge got=%0d expected=%0d", edge_n, exp_e);
        end
      end
    end
    pulso_ant = (pulso === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog edge=%0d got=timeout expected=finish", edge_n);
    $fatal(1, "timeout");
  end

  task automatic wait_neg(input int alvo);
    while (edge_n < alvo) @(negedge clk);
  endtask

  // Model of strobes for one stay in PRESSIONADO from entrada until saida
  task automatic push_press(input int entrada, input int saida, input bit com_entrada,
                            inout int n);
    if (com_entrada) begin
      exp_q.push_back(entrada);
      n++;
    end
`ifdef GERADOR_PULSO_AUTO_REPEAT_EN
    for (int e = entrada + 8; e < saida; e += 3) begin
      exp_q.push_back(e);
      n++;
    end
`endif
  endtask

  task automatic test_reset();
    clear = 1'b1;
    #3 clear = 1'b0;
    #1;
    checks++;
    if (pulso !== 1'b0) begin failures++; $display("FAIL reset_pulso got=%b expected=0", pulso); end
    checks++;
    if (estavel !== 1'b0) begin failures++; $display("FAIL reset_estavel got=%b expected=0", estavel); end
    repeat (3) @(negedge clk);
    checks++;
    if ({pulso, estavel} !== 2'b00) begin
      failures++; $display("FAIL reset_hold got=%b expected=00", {pulso, estavel});
    end
    clear = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clean_press();
    int t0, k, np;
    logic [3:0] c0, d;
    np = 0; c0 = cont4;
    botao = 1'b1; t0 = edge_n + 1;
    push_press(t0 + 5, t0 + 22, 1'b1, np);
    wait_neg(t0 + 4);
    checks++;
    if (estavel !== 1'b0) begin failures++; $display("FAIL clean_estavel_early got=%b expected=0", estavel); end
    wait_neg(t0 + 5);
    checks++;
    if (estavel !== 1'b1) begin failures++; $display("FAIL clean_estavel_rise got=%b expected=1", estavel); end
    wait_neg(t0 + 19);
    botao = 1'b0; k = t0 + 20;
    wait_neg(k + 4);
    checks++;
    if (estavel !== 1'b1) begin failures++; $display("FAIL clean_estavel_hold got=%b expected=1", estavel); end
    wait_neg(k + 5);
    checks++;
    if (estavel !== 1'b0) begin failures++; $display("FAIL clean_estavel_fall got=%b expected=0", estavel); end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL clean_pendentes got=%0d expected=0", exp_q.size()); end
    d = cont4 - c0;
    checks++;
    if (d !== 4'(np)) begin failures++; $display("FAIL clean_contador got=%0d expected=%0d", d, np); end
  endtask

  task automatic test_bounce_press();
    int b, s, np;
    np = 0;
    b = edge_n + 1;
    botao = 1'b1; @(negedge clk);
    botao = 1'b0; @(negedge clk);
    botao = 1'b1; @(negedge clk);
    botao = 1'b0; @(negedge clk);
    botao = 1'b1; s = b + 4;
    push_press(s + 5, s + 12, 1'b1, np);
    wait_neg(s + 4);
    checks++;
    if (estavel !== 1'b0) begin failures++; $display("FAIL bounce_estavel_early got=%b expected=0", estavel); end
    wait_neg(s + 5);
    checks++;
    if (estavel !== 1'b1) begin failures++; $display("FAIL bounce_estavel_rise got=%b expected=1", estavel); end
    wait_neg(s + 9);
    botao = 1'b0;
    wait_neg(s + 16);
    checks++;
    if (estavel !== 1'b0) begin failures++; $display("FAIL bounce_estavel_idle got=%b expected=0", estavel); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL bounce_pendentes got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_release_bounce();
    int p, k, np;
    logic [3:0] c0, d;
    np = 0; c0 = cont4;
    botao = 1'b1; p = edge_n + 1;
    push_press(p + 5, p + 10, 1'b1, np);
    wait_neg(p + 7);  botao = 1'b0;
    wait_neg(p + 9);  botao = 1'b1;
    wait_neg(p + 10); botao = 1'b0; k = p + 11;
    wait_neg(p + 11);
    checks++;
    if (estavel !== 1'b1) begin failures++; $display("FAIL solta_estavel_bounce got=%b expected=1", estavel); end
    wait_neg(k + 4);
    checks++;
    if (estavel !== 1'b1) begin failures++; $display("FAIL solta_estavel_hold got=%b expected=1", estavel); end
    wait_neg(k + 5);
    checks++;
    if (estavel !== 1'b0) begin failures++; $display("FAIL solta_estavel_fall got=%b expected=0", estavel); end
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL solta_pendentes got=%0d expected=0", exp_q.size()); end
    d = cont4 - c0;
    checks++;
    if (d !== 4'(np)) begin failures++; $display("FAIL solta_contador got=%0d expected=%0d", d, np); end
  endtask

  task automatic test_habilita();
    int q, q2, np;
    logic [3:0] c0, d;
    np = 0; c0 = cont4;
    habilita = 1'b0; botao = 1'b1; q = edge_n + 1;
    // Enable returns after the acceptance strobe: that strobe is lost
    push_press(q + 5, q + 14, 1'b0, np);
    wait_neg(q + 6);
    habilita = 1'b1;
    checks++;
    if (estavel !== 1'b1) begin failures++; $display("FAIL hab_estavel got=%b expected=1", estavel); end
    wait_neg(q + 11); botao = 1'b0;
    wait_neg(q + 20);
    botao = 1'b1; q2 = edge_n + 1;
    push_press(q2 + 5, q2 + 10, 1'b1, np);
    wait_neg(q2 + 7); botao = 1'b0;
    wait_neg(q2 + 16);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL hab_pendentes got=%0d expected=0", exp_q.size()); end
    d = cont4 - c0;
    checks++;
    if (d !== 4'(np)) begin failures++; $display("FAIL hab_contador got=%0d expected=%0d", d, np); end
  endtask

  task automatic test_clear_async();
    int t0, t1;
    botao = 1'b1; t0 = edge_n + 1;
    wait_neg(t0 + 4);
    #2 clear = 1'b0;
    #1;
    checks++;
    if ({pulso, estavel} !== 2'b00) begin
      failures++; $display("FAIL clr_filtra got=%b expected=00", {pulso, estavel});
    end
    wait_neg(t0 + 6);
    checks++;
    if ({pulso, estavel} !== 2'b00) begin
      failures++; $display("FAIL clr_held got=%b expected=00", {pulso, estavel});
    end
    clear = 1'b1; t1 = edge_n + 1;
    wait_neg(t1 + 4);
    checks++;
    if (estavel !== 1'b0) begin failures++; $display("FAIL clr_estavel_early got=%b expected=0", estavel); end
    @(posedge clk); #1;
    checks++;
    if ({pulso, estavel} !== 2'b11) begin
      failures++; $display("FAIL clr_pulso_latencia got=%b expected=11", {pulso, estavel});
    end
    #1 clear = 1'b0;
    #1;
    checks++;
    if ({pulso, estavel} !== 2'b00) begin
      failures++; $display("FAIL clr_async_press got=%b expected=00", {pulso, estavel});
    end
    @(negedge clk);
    botao = 1'b0; clear = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL clr_pendentes got=%0d expected=0", exp_q.size()); end
  endtask

`ifdef GERADOR_PULSO_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    int t0, np;
    logic [3:0] c0, d;
    np = 0; c0 = cont4;
    botao = 1'b1; t0 = edge_n + 1;
    push_press(t0 + 5, t0 + 32, 1'b1, np);
    wait_neg(t0 + 29); botao = 1'b0;
    wait_neg(t0 + 40);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rep_pendentes got=%0d expected=0", exp_q.size()); end
    d = cont4 - c0;
    checks++;
    if (d !== 4'd8) begin failures++; $display("FAIL rep_contador got=%0d expected=8", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_press();
    test_release_bounce();
    test_habilita();
    test_clear_async();
`ifdef GERADOR_PULSO_AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_gerador_pulso_debounce
`default_nettype wire
